// File: rtl/ram_burst_pkg.sv
// Shared state encoding and default widths for the RAM burst master and its read skid buffer.
package ram_burst_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry read-data FIFO between RAM q and the read stream; data is visible the cycle after push.
// out_dat holds steady while out_vld is high and out_rdy is low; the caller never pushes into a full buffer.
module ram_rd_skid
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;

  assign push    = in_vld && (count != 2'd2);
  assign pop     = out_vld && out_rdy;
  assign out_vld = (count != 2'd0);
  assign out_dat = mem[rd_ptr];
  assign occ     = count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM: write beats land on their handshake edge; first read beat 2 cycles after accept.
// Read issue is throttled so no more than 2 words are ever buffered; rd_ready low stalls issue without losing data.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_data_q;
  logic                  in_flight;
  logic                  cmd_acc;
  logic                  wr_beat;
  logic                  rd_issue;
  logic                  rd_room;
  logic                  skid_pop;
  logic [1:0]            skid_occ;
  logic [1:0]            occ_after;

  assign cmd_acc  = cmd_valid && cmd_ready;
  assign skid_pop = rd_valid && rd_ready;

  // Count the beat leaving this cycle as already gone so a streaming consumer sees one beat per cycle.
  assign occ_after = skid_occ - {1'b0, skid_pop};
  assign rd_room   = (occ_after == 2'd0) || ((occ_after == 2'd1) && !in_flight);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ram_addr_q;
    ram_data  = ram_data_q;
    wr_beat   = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        busy     = 1'b1;
        wr_ready = 1'b1;
        if (wr_valid) begin
          wr_beat  = 1'b1;
          ram_we   = 1'b1;
          ram_addr = addr_cnt;
          ram_data = wr_data;
          if (beat_cnt == '0) state_nxt = DONE;
        end
      end
      READ: begin
        busy = 1'b1;
        if (rd_room) begin
          rd_issue = 1'b1;
          ram_addr = addr_cnt;
          if (beat_cnt == '0) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!in_flight && (skid_occ == 2'd0)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      beat_cnt   <= '0;
      in_flight  <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state      <= state_nxt;
      in_flight  <= rd_issue;
      ram_addr_q <= ram_addr;
      ram_data_q <= ram_data;
      if (cmd_acc) begin
        addr_cnt <= cmd_addr;
        beat_cnt <= cmd_len;
      end else if (wr_beat || rd_issue) begin
        addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
        beat_cnt <= beat_cnt - ADDR_WIDTH'(1);
      end
    end
  end

  ram_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr    (cmd_acc),
    .in_vld (in_flight),
    .in_dat (ram_q),
    .out_vld(rd_valid),
    .out_rdy(rd_ready),
    .out_dat(rd_data),
    .occ    (skid_occ)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master with a behavioural single-port RAM and a read-data scoreboard.
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_len = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] ram_data;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int gap_cnt = 0;
  int first_rd_cyc = -1;
  int last_rd_cyc = -1;

  logic [7:0] ram_mem [256];
  logic [7:0] ref_mem [256];
  logic       ref_vld [256];
  logic [7:0] exp_q [$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_dat = 8'h00;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] len;
    logic [7:0] seed;
    int         gap;
    logic [3:0] pat;
    int         exp_we;
    int         exp_done;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];

  ram_burst_master #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .busy     (busy),
    .done     (done),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_q    (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  always @(posedge clk) cyc = cyc + 1;

  // Negedge monitor: values here are what the next posedge will act on.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (ram_we) we_cnt = we_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
      if (hold_pend) begin
        checks = checks + 1;
        if (!rd_valid || rd_data !== hold_dat) begin
          errors = errors + 1;
          $display("FAIL rd_hold: valid=%0b data=%02h required valid=1 data=%02h", rd_valid, rd_data, hold_dat);
        end
      end
      hold_pend = rd_valid && !rd_ready;
      hold_dat  = rd_data;
      if (rd_valid && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (rd_valid && rd_ready) begin
        if (last_rd_cyc >= 0 && cyc != last_rd_cyc + 1) gap_cnt = gap_cnt + 1;
        last_rd_cyc = cyc;
        rd_cnt = rd_cnt + 1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL rd_extra: got beat %02h required no beat", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors = errors + 1;
            $display("FAIL rd_data: got %02h required %02h", rd_data, e);
          end
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_ram();
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (ref_vld[i] && ram_mem[i] !== ref_mem[i]) bad++;
    chk("ram_contents_bad_words", bad, 0);
  endtask

  // Entered and left just after a posedge; offers a command until accepted, then scrambles the fields.
  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] len, output int acc);
    int n = 0;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("cmd_ready_seen", int'(cmd_ready), 1);
    acc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_len   = 8'h05;
    #2;
    chk("busy_after_accept", int'(busy), 1);
    chk("cmd_ready_low_busy", int'(cmd_ready), 0);
  endtask

  task automatic wait_done(output int dcyc);
    int n = 0;
    logic got = 1'b0;
    dcyc = -1;
    while (!got && n < 2000) begin
      @(negedge clk);
      n++;
      if (done) begin
        got  = 1'b1;
        dcyc = cyc;
        chk("cmd_ready_in_done", int'(cmd_ready), 0);
      end
    end
    chk("done_seen", int'(got), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_write(input logic [7:0] addr, input logic [7:0] len, input logic [7:0] seed,
                           input int gap, input int exp_we, input int exp_done, input int exp_lat);
    int acc, we0, d0, lastc, dcyc, n;
    logic [7:0] d;
    logic [7:0] a;
    we0 = we_cnt;
    d0  = done_cnt;
    lastc = -1;
    wr_valid = 1'b0;
    send_cmd(1'b1, addr, len, acc);
    for (int i = 0; i <= int'(len); i++) begin
      if (gap > 0 && (i % 3) == 1) begin
        wr_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      d = seed + 8'(i * 17);
      a = addr + 8'(i);
      wr_valid = 1'b1;
      wr_data  = d;
      n = 0;
      @(negedge clk);
      while (!wr_ready && n < 20) begin
        n++;
        @(negedge clk);
      end
      if (!wr_ready) chk("wr_ready_timeout", 0, 1);
      lastc = cyc;
      @(posedge clk);
      #1;
      ref_mem[a] = d;
      ref_vld[a] = 1'b1;
    end
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    wait_done(dcyc);
    chk("wr_done_latency", dcyc - lastc, exp_lat);
    chk("wr_we_pulses", we_cnt - we0, exp_we);
    chk("wr_done_pulses", done_cnt - d0, exp_done);
    chk("busy_after_done", int'(busy), 0);
    check_ram();
  endtask

  task automatic run_read(input logic [7:0] addr, input logic [7:0] len, input logic [3:0] pat,
                          input int exp_we, input int exp_done, input int exp_lat);
    int acc, we0, d0, r0, k, n;
    logic got = 1'b0;
    we0 = we_cnt;
    d0  = done_cnt;
    r0  = rd_cnt;
    first_rd_cyc = -1;
    last_rd_cyc  = -1;
    gap_cnt      = 0;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(ref_mem[addr + 8'(i)]);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    rd_ready = pat[0];
    send_cmd(1'b0, addr, len, acc);
    k = 1;
    n = 0;
    while (!got && n < 3000) begin
      rd_ready = pat[2'(k)];
      k++;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("cmd_ready_in_done", int'(cmd_ready), 0);
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("rd_done_seen", int'(got), 1);
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rd_beats", rd_cnt - r0, int'(len) + 1);
    chk("rd_left_in_queue", exp_q.size(), 0);
    exp_q.delete();
    chk("rd_we_pulses", we_cnt - we0, exp_we);
    chk("rd_done_pulses", done_cnt - d0, exp_done);
    chk("busy_after_done", int'(busy), 0);
    if (exp_lat >= 0) begin
      chk("rd_first_latency", first_rd_cyc - (acc + 1), exp_lat);
      chk("rd_stream_gaps", gap_cnt, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, d0, r0, n;
    for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;

    vecs[0] = '{1'b1, 8'h10, 8'h03, 8'hA1, 0, 4'hF, 4, 1, 1};
    vecs[1] = '{1'b0, 8'h10, 8'h03, 8'h00, 0, 4'hF, 0, 1, 2};
    vecs[2] = '{1'b1, 8'h20, 8'h07, 8'h05, 0, 4'hF, 8, 1, 1};
    vecs[3] = '{1'b0, 8'h20, 8'h07, 8'h00, 0, 4'b1001, 0, 1, -1};
    vecs[4] = '{1'b1, 8'hFE, 8'h03, 8'h3C, 0, 4'hF, 4, 1, 1};
    vecs[5] = '{1'b0, 8'hFE, 8'h03, 8'h00, 0, 4'hF, 0, 1, 2};
    vecs[6] = '{1'b1, 8'h40, 8'h05, 8'h77, 2, 4'hF, 6, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_data", int'(ram_data), 0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].wr)
        run_write(vecs[v].addr, vecs[v].len, vecs[v].seed, vecs[v].gap,
                  vecs[v].exp_we, vecs[v].exp_done, vecs[v].exp_lat);
      else
        run_read(vecs[v].addr, vecs[v].len, vecs[v].pat,
                 vecs[v].exp_we, vecs[v].exp_done, vecs[v].exp_lat);
    end

    // Full-depth burst with stalls on the write stream, then read everything back.
    run_write(8'h00, 8'hFF, 8'h5A, 1, 256, 1, 1);
    run_read(8'h00, 8'hFF, 4'hF, 0, 1, 2);

    // Reset in the middle of a read burst after two beats have been taken.
    d0 = done_cnt;
    r0 = rd_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(ref_mem[8'h20 + 8'(i)]);
    rd_ready = 1'b1;
    send_cmd(1'b0, 8'h20, 8'h07, acc);
    n = 0;
    while (rd_cnt < r0 + 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_mid_beats_before", rd_cnt - r0, 2);
    rst      = 1'b1;
    rd_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_mid_rd_valid", int'(rd_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_rd_valid_after", int'(rd_valid), 0);
    run_read(8'hFE, 8'h03, 4'hF, 0, 1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
